// File: rtl/shift_pkg.sv
// Shared types for the pipelined operand-2 shifter: shift types, amount form,
// and the special-case control word that rides alongside each in-flight operand.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_type_t;

    localparam logic SH_IMM = 1'b0;
    localparam logic SH_REG = 1'b1;

    // Special cases are decoded at intake and only applied after the last mux level.
    typedef struct packed {
        sh_type_t typ;
        logic     zero_res;
        logic     sign_res;
        logic     rrx;
        logic     c_ovr;
        logic     c_val;
    } sh_ctrl_t;

    function automatic int level_start(input int stage, input int levels, input int stages);
        return (stage * levels) / stages;
    endfunction

endpackage

// File: rtl/pipelined_shifter_level.sv
// One mux level of the shifter: optionally shifts/rotates by DIST and tracks the
// last bit shifted out so the final enabled level leaves the architectural carry.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             carry,
    input  logic             en,
    input  sh_type_t         typ,
    input  logic             fill,
    output logic [WIDTH-1:0] result,
    output logic             result_carry
);

    always_comb begin
        result       = data;
        result_carry = carry;
        if (en) begin
            case (typ)
                SH_LSL: begin
                    result       = data << DIST;
                    result_carry = data[WIDTH-DIST];
                end
                SH_LSR, SH_ASR: begin
                    result       = {{DIST{fill}}, data[WIDTH-1:DIST]};
                    result_carry = data[DIST-1];
                end
                SH_ROR: begin
                    // rotate carry is taken from the final result, not per level
                    result       = {data[DIST-1:0], data[WIDTH-1:DIST]};
                    result_carry = carry;
                end
                default: begin
                    result       = data;
                    result_carry = carry;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// ARMv7 operand-2 shifter: log2(WIDTH) mux levels spread over LATENCY register
// stages, global stall, flush of in-flight entries, pass-through tag.
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int AMT_W   = 8,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LG = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic [LG-1:0]    amt;
        sh_ctrl_t         ctrl;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Returns the stage whose registers feed level i, or 0 if level i is fed combinationally.
    function automatic int boundary(input int i);
        int r;
        r = 0;
        for (int s = 1; s < LATENCY; s++)
            if (level_start(s, LG, LATENCY) == i) r = s;
        return r;
    endfunction

    function automatic stage_t finish(input stage_t x);
        stage_t           r;
        logic [WIDTH-1:0] res;
        r = x;
        if (x.ctrl.zero_res)      res = '0;
        else if (x.ctrl.sign_res) res = {WIDTH{x.ctrl.c_val}};
        else if (x.ctrl.rrx)      res = {x.carry, x.data[WIDTH-1:1]};
        else                      res = x.data;
        r.data = res;
        if (x.ctrl.c_ovr)               r.carry = x.ctrl.c_val;
        else if (x.ctrl.typ == SH_ROR)  r.carry = res[WIDTH-1];
        else                            r.carry = x.carry;
        return r;
    endfunction

    sh_ctrl_t         ctrl;
    sh_type_t         typ;
    logic [LG-1:0]    n_low;
    logic             msb;
    logic             amt_eq_w;
    logic             amt_gt_w;
    stage_t           lv    [0:LG];
    stage_t           lv_in [0:LG-1];
    stage_t           st_d  [0:LATENCY-1];
    stage_t           st_q  [0:LATENCY-1];
    logic [LATENCY-1:0] vld;
    logic             advance;

    assign typ      = sh_type_t'(in_op[2:1]);
    assign n_low    = in_amt[LG-1:0];
    assign msb      = in_data[WIDTH-1];
    assign amt_eq_w = (in_amt == AMT_W'(WIDTH));
    assign amt_gt_w = (in_amt >  AMT_W'(WIDTH));

    always_comb begin
        ctrl     = '0;
        ctrl.typ = typ;
        if (in_op[0] == SH_IMM) begin
            if (n_low == '0) begin
                case (typ)
                    SH_LSR: begin ctrl.zero_res = 1'b1; ctrl.c_ovr = 1'b1; ctrl.c_val = msb; end
                    SH_ASR: begin ctrl.sign_res = 1'b1; ctrl.c_ovr = 1'b1; ctrl.c_val = msb; end
                    SH_ROR: begin ctrl.rrx = 1'b1; ctrl.c_ovr = 1'b1; ctrl.c_val = in_data[0]; end
                    default: ctrl.c_ovr = 1'b0;
                endcase
            end
        end else if (in_amt == '0) begin
            ctrl.c_ovr = 1'b1;
            ctrl.c_val = in_carry;
        end else begin
            case (typ)
                SH_LSL: begin
                    if (amt_eq_w || amt_gt_w) begin
                        ctrl.zero_res = 1'b1;
                        ctrl.c_ovr    = 1'b1;
                        ctrl.c_val    = amt_eq_w & in_data[0];
                    end
                end
                SH_LSR: begin
                    if (amt_eq_w || amt_gt_w) begin
                        ctrl.zero_res = 1'b1;
                        ctrl.c_ovr    = 1'b1;
                        ctrl.c_val    = amt_eq_w & msb;
                    end
                end
                SH_ASR: begin
                    if (amt_eq_w || amt_gt_w) begin
                        ctrl.sign_res = 1'b1;
                        ctrl.c_ovr    = 1'b1;
                        ctrl.c_val    = msb;
                    end
                end
                SH_ROR: begin
                    // a nonzero multiple of WIDTH rotates back to the operand itself
                    if (n_low == '0) begin
                        ctrl.c_ovr = 1'b1;
                        ctrl.c_val = msb;
                    end
                end
                default: ctrl.c_ovr = 1'b0;
            endcase
        end
    end

    assign lv[0] = {in_data, in_carry, n_low, ctrl, in_tag};

    for (genvar i = 0; i < LG; i++) begin : g_lvl
        localparam int B = boundary(i);
        logic [WIDTH-1:0] d;
        logic             c;

        if (B > 0) begin : g_reg
            assign lv_in[i] = st_q[B-1];
        end else begin : g_comb
            assign lv_in[i] = lv[i];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_level (
            .data         (lv_in[i].data),
            .carry        (lv_in[i].carry),
            .en           (lv_in[i].amt[i]),
            .typ          (lv_in[i].ctrl.typ),
            .fill         ((lv_in[i].ctrl.typ == SH_ASR) & lv_in[i].data[WIDTH-1]),
            .result       (d),
            .result_carry (c)
        );

        assign lv[i+1] = {d, c, lv_in[i].amt, lv_in[i].ctrl, lv_in[i].tag};
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        if (s == LATENCY - 1) begin : g_last
            assign st_d[s] = finish(lv[LG]);
        end else begin : g_mid
            assign st_d[s] = lv[level_start(s + 1, LG, LATENCY)];
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int s = 0; s < LATENCY; s++) st_q[s] <= '0;
        end else begin
            if (flush) begin
                vld <= '0;
            end else if (advance) begin
                vld[0] <= in_valid;
                for (int s = 1; s < LATENCY; s++) vld[s] <= vld[s-1];
            end
            if (advance) begin
                for (int s = 0; s < LATENCY; s++) st_q[s] <= st_d[s];
            end
        end
    end

    assign out_data  = st_q[LATENCY-1].data;
    assign out_carry = st_q[LATENCY-1].carry;
    assign out_tag   = st_q[LATENCY-1].tag;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: shift edge cases, back-pressure ordering,
// flush and asynchronous reset behaviour with hand-computed expectations.
module tb_pipelined_shifter;

    localparam int WIDTH   = 32;
    localparam int AMT_W   = 8;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 4;

    localparam logic [2:0] LSL_I = 3'b000, LSL_R = 3'b001;
    localparam logic [2:0] LSR_I = 3'b010, LSR_R = 3'b011;
    localparam logic [2:0] ASR_I = 3'b100, ASR_R = 3'b101;
    localparam logic [2:0] ROR_I = 3'b110, ROR_R = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_op;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    pipelined_shifter #(
        .WIDTH   (WIDTH),
        .AMT_W   (AMT_W),
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready high and check result, carry, tag and latency.
    task automatic run_vec(input string name, input logic [31:0] d, input logic [2:0] op,
                           input logic [7:0] amt, input logic c, input logic [3:0] tg,
                           input logic [31:0] exp_d, input logic exp_c);
        int cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_op     = op;
        in_amt    = amt;
        in_carry  = c;
        in_tag    = tg;
        chk({name, "_rdy"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        chk({name, "_lat"}, 64'(cyc), 64'(LATENCY));
        chk({name, "_data"}, 64'(out_data), 64'(exp_d));
        chk({name, "_carry"}, 64'(out_carry), 64'(exp_c));
        chk({name, "_tag"}, 64'(out_tag), 64'(tg));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, cyc;
        logic hold;
        logic [WIDTH-1:0] saved_d;
        logic [TAG_W-1:0] saved_t;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
        in_carry = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_carry", 64'(out_carry), 64'd0);
        chk("rst_tag",   64'(out_tag),   64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        step();

        run_vec("lsl_i1",    32'h80000001, LSL_I, 8'd1,    1'b0, 4'd1, 32'h00000002, 1'b1);
        run_vec("lsr_i0",    32'h80000001, LSR_I, 8'd0,    1'b1, 4'd2, 32'h00000000, 1'b1);
        run_vec("asr_i0",    32'h80000001, ASR_I, 8'd0,    1'b1, 4'd3, 32'hFFFFFFFF, 1'b1);
        run_vec("rrx",       32'h80000001, ROR_I, 8'd0,    1'b1, 4'd4, 32'hC0000000, 1'b1);
        run_vec("lsl_r32",   32'h0000000F, LSL_R, 8'd32,   1'b0, 4'd5, 32'h00000000, 1'b1);
        run_vec("lsl_r33",   32'h0000000F, LSL_R, 8'd33,   1'b1, 4'd6, 32'h00000000, 1'b0);
        run_vec("ror_r32",   32'h0000000F, ROR_R, 8'd32,   1'b1, 4'd7, 32'h0000000F, 1'b0);
        run_vec("ror_r4",    32'h0000000F, ROR_R, 8'd4,    1'b0, 4'd8, 32'hF0000000, 1'b1);
        run_vec("asr_r0",    32'h0000000F, ASR_R, 8'd0,    1'b1, 4'd9, 32'h0000000F, 1'b1);
        run_vec("lsl_i0",    32'h12345678, LSL_I, 8'd0,    1'b0, 4'd10, 32'h12345678, 1'b0);
        run_vec("asr_i4",    32'h80000010, ASR_I, 8'd4,    1'b1, 4'd11, 32'hF8000001, 1'b0);
        run_vec("lsl_i_hi",  32'h00000001, LSL_I, 8'h21,   1'b1, 4'd12, 32'h00000002, 1'b0);
        run_vec("lsr_r4",    32'h0000000F, LSR_R, 8'd4,    1'b0, 4'd13, 32'h00000000, 1'b1);
        run_vec("lsr_r32",   32'h80000000, LSR_R, 8'd32,   1'b0, 4'd14, 32'h00000000, 1'b1);
        run_vec("lsr_r40",   32'h80000000, LSR_R, 8'd40,   1'b1, 4'd15, 32'h00000000, 1'b0);
        run_vec("asr_r40",   32'h80000000, ASR_R, 8'd40,   1'b0, 4'd0, 32'hFFFFFFFF, 1'b1);
        run_vec("ror_i8",    32'h12345678, ROR_I, 8'd8,    1'b1, 4'd1, 32'h78123456, 1'b0);
        run_vec("lsl_r31",   32'h00000003, LSL_R, 8'd31,   1'b0, 4'd2, 32'h80000000, 1'b1);

        // back-pressure: tags 0..7, LSL #1 of tag<<4
        sent = 0; got = 0; hold = 1'b0; saved_d = '0; saved_t = '0;
        in_op = LSL_I; in_amt = 8'd1; in_carry = 1'b0;
        for (cyc = 0; cyc < 300 && got < 8; cyc++) begin
            out_ready = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            in_valid  = (sent < 8);
            in_data   = 32'(sent) << 4;
            in_tag    = TAG_W'(sent);
            #3;
            if (hold) begin
                chk("bp_hold_data", 64'(out_data), 64'(saved_d));
                chk("bp_hold_tag",  64'(out_tag),  64'(saved_t));
            end
            if (out_valid && out_ready) begin
                chk("bp_tag",  64'(out_tag),  64'(got));
                chk("bp_data", 64'(out_data), 64'(got) << 5);
                got++;
            end
            hold    = out_valid && !out_ready;
            saved_d = out_data;
            saved_t = out_tag;
            if (in_valid && in_ready) sent++;
            step();
        end
        chk("bp_count", 64'(got), 64'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // flush with two entries held and a third request offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; in_tag = 4'd1;
        step();
        in_tag = 4'd2;
        step();
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1; in_tag = 4'd3;
        #1;
        chk("fl_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fl_empty", 64'(out_valid), 64'd0);
            step();
        end
        run_vec("fl_next", 32'h00000001, LSL_I, 8'd3, 1'b0, 4'd9, 32'h00000008, 1'b0);

        // asynchronous reset with an entry on the output
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; in_op = LSL_I; in_amt = 8'd0; in_tag = 4'd6;
        step();
        in_valid = 1'b0;
        step();
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_tag",   64'(out_tag),   64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ar_ready", 64'(in_ready), 64'd1);
        step();
        run_vec("ar_next", 32'hF0000000, LSR_I, 8'd4, 1'b0, 4'd11, 32'h0F000000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
